// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port clearable RAM.
package ram_pkg;

  // Controller state: sweeping zeros through the array, or serving accesses.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Collision policy when reading and writing the same address in one cycle.
  localparam int unsigned RD_OLD = 0;  // read returns the pre-write word
  localparam int unsigned RD_WT  = 1;  // read returns the word merged with the write

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear-sweep controller: walks clr_ptr over every address after reset or on
// request, and flags the array as busy until the sweep has finished.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int unsigned AddrW = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_req_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [AddrW-1:0] clr_ptr_o
);

  localparam logic [AddrW-1:0] LastPtr = '1;

  state_e           state_q;
  logic [AddrW-1:0] clr_ptr_q;
  logic             busy_q;

  // State, sweep pointer and registered busy flag advance together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          if (clr_ptr_q == LastPtr) begin
            state_q   <= READY;
            clr_ptr_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
          end
        end
        READY: begin
          if (clr_req_i) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Sweep writes are suppressed while reset is held so the array is untouched.
  assign clr_we_o  = (state_q == CLEAR) && rst_ni;
  assign busy_o    = busy_q;
  assign clr_ptr_o = clr_ptr_q;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM with byte-enabled writes, registered reads and a
// self-timed full-array clear sweep.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned RD_MODE = RD_OLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_req,
  input  logic                wr_enb,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                rd_enb,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned ByteN = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_word;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_ptr;
  logic              acc_ok;

  ram_clr_fsm #(
    .AddrW(ADDR_W)
  ) u_clr_fsm (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clr_req_i(clr_req),
    .busy_o   (busy),
    .clr_we_o (clr_we),
    .clr_ptr_o(clr_ptr)
  );

  // Port accesses are honoured only when out of reset and not sweeping.
  assign acc_ok = rst && !busy;

  // Array write port: sweep zeros take priority, otherwise byte-masked write.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ptr] <= '0;
    end else if (acc_ok && wr_enb) begin
      for (int i = 0; i < ByteN; i++) begin
        if (byte_en[i]) begin
          mem_q[wr_addr][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  // Read word selection, forwarding write lanes on a same-address collision.
  always_comb begin
    rd_word = mem_q[rd_addr];
    if (RD_MODE == RD_WT && wr_enb && wr_addr == rd_addr) begin
      for (int i = 0; i < ByteN; i++) begin
        if (byte_en[i]) begin
          rd_word[8*i +: 8] = data_in[8*i +: 8];
        end
      end
    end
  end

  // Registered read data and its one-cycle valid strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else if (!busy && rd_enb) begin
      data_out_q <= rd_word;
      rd_valid_q <= 1'b1;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: read-old and write-through builds driven in lockstep
// and compared every cycle against a word-array reference model.
module tb_ram_dp_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_req;
  logic        wr_enb;
  logic [2:0]  wr_addr;
  logic [1:0]  byte_en;
  logic [15:0] data_in;
  logic        rd_enb;
  logic [2:0]  rd_addr;

  logic [15:0] do0, do1;
  logic        rv0, rv1, busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_clr #(.DATA_W(16), .ADDR_W(3), .RD_MODE(0)) u_dut_old (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_enb(wr_enb), .wr_addr(wr_addr),
    .byte_en(byte_en), .data_in(data_in), .rd_enb(rd_enb), .rd_addr(rd_addr),
    .data_out(do0), .rd_valid(rv0), .busy(busy0)
  );

  ram_dp_clr #(.DATA_W(16), .ADDR_W(3), .RD_MODE(1)) u_dut_wt (
    .clk(clk), .rst(rst), .clr_req(clr_req), .wr_enb(wr_enb), .wr_addr(wr_addr),
    .byte_en(byte_en), .data_in(data_in), .rd_enb(rd_enb), .rd_addr(rd_addr),
    .data_out(do1), .rd_valid(rv1), .busy(busy1)
  );

  // Reference model state.
  logic [15:0] m_mem [8];
  int          clr_left = 0;
  logic [15:0] e_do0 = '0;
  logic [15:0] e_do1 = '0;
  logic        e_rv = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  // Advance one clock: update the model from the current inputs, then compare.
  task automatic cyc();
    logic [15:0] old_w;
    if (!rst) begin
      clr_left = 8;
      e_do0    = '0;
      e_do1    = '0;
      e_rv     = 1'b0;
    end else if (clr_left > 0) begin
      m_mem[8 - clr_left] = '0;
      clr_left--;
      e_rv = 1'b0;
    end else begin
      old_w = m_mem[rd_addr];
      if (rd_enb) begin
        e_do0 = old_w;
        e_do1 = (wr_enb && wr_addr == rd_addr) ? merge(old_w, data_in, byte_en) : old_w;
        e_rv  = 1'b1;
      end else begin
        e_rv = 1'b0;
      end
      if (wr_enb) m_mem[wr_addr] = merge(m_mem[wr_addr], data_in, byte_en);
      if (clr_req) clr_left = 8;
    end
    @(posedge clk);
    #1;
    check("busy_old",  32'(busy0), 32'(clr_left > 0));
    check("busy_wt",   32'(busy1), 32'(clr_left > 0));
    check("valid_old", 32'(rv0), 32'(e_rv));
    check("valid_wt",  32'(rv1), 32'(e_rv));
    check("dout_old",  32'(do0), 32'(e_do0));
    check("dout_wt",   32'(do1), 32'(e_do1));
  endtask

  task automatic idle();
    clr_req = 1'b0;
    wr_enb  = 1'b0;
    rd_enb  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    idle();
    wr_enb = 1'b1; wr_addr = a; data_in = d; byte_en = be;
    cyc();
  endtask

  task automatic rd(input logic [2:0] a);
    idle();
    rd_enb = 1'b1; rd_addr = a;
    cyc();
  endtask

  // Counts busy samples over n cycles of ignored random traffic.
  task automatic count_busy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (busy0) cnt++;
      clr_req = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_enb  = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_enb  = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_addr = 3'($urandom);
      rd_addr = 3'($urandom);
      byte_en = 2'b11;
      data_in = 16'hFFFF;
      cyc();
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    idle();
    wr_addr = '0; rd_addr = '0; byte_en = '0; data_in = '0;

    // Reset held two cycles, then the power-on sweep.
    cyc();
    cyc();
    rst = 1'b1;
    count_busy(10, n);
    check("init_clear_len", 32'(n), 32'd8);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("init_zero", 32'(do0), 32'h0);
    end

    // Byte-masked overwrite.
    wr(3'd4, 16'hABCD, 2'b11);
    wr(3'd4, 16'h1234, 2'b01);
    rd(3'd4);
    check("bytemask", 32'(do0), 32'hAB34);

    // Same-address collision under both policies.
    wr(3'd5, 16'h0005, 2'b11);
    idle();
    wr_enb = 1'b1; wr_addr = 3'd5; data_in = 16'h000A; byte_en = 2'b11;
    rd_enb = 1'b1; rd_addr = 3'd5;
    cyc();
    check("coll_old", 32'(do0), 32'h0005);
    check("coll_wt",  32'(do1), 32'h000A);
    rd(3'd5);
    check("after_coll", 32'(do0), 32'h000A);

    // Requested clear with writes attempted during the sweep.
    for (int a = 0; a < 8; a++) wr(3'(a), 16'h1111, 2'b11);
    idle();
    clr_req = 1'b1;
    cyc();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy0) n++;
      idle();
      wr_enb = 1'b1; wr_addr = 3'd2; data_in = 16'hFFFF; byte_en = 2'b11;
      if (i >= 8) wr_enb = 1'b0;
      cyc();
    end
    check("req_clear_len", 32'(n), 32'd8);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      check("cleared", 32'(do0), 32'h0);
    end

    // Reset mid-sweep restarts the full sweep.
    wr(3'd7, 16'h7777, 2'b11);
    idle();
    clr_req = 1'b1;
    cyc();
    idle();
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    count_busy(10, n);
    check("restart_clear_len", 32'(n), 32'd8);

    // Independent read and write in one cycle.
    idle();
    wr_enb = 1'b1; wr_addr = 3'd1; data_in = 16'h00FF; byte_en = 2'b11;
    rd_enb = 1'b1; rd_addr = 3'd6;
    cyc();
    check("split_rd", 32'(do0), 32'h0000);
    rd(3'd1);
    check("split_wr", 32'(do0), 32'h00FF);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 199) != 0);
      clr_req = ($urandom_range(0, 39) == 0);
      wr_enb  = 1'($urandom_range(0, 1));
      rd_enb  = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom);
      rd_addr = $urandom_range(0, 1) ? wr_addr : 3'($urandom);
      byte_en = 2'($urandom);
      data_in = 16'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_dp_clr.md
RAM_DP_CLR -- requirements
Module: ram_dp_clr

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_MODE, default 0, collision policy (0 = read-old, 1 = write-through).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port clr_req  input  1  request full-array clear (one-cycle pulse, sampled when idle).
REQ-007 SHALL have port wr_enb  input  1  write enable.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-009 SHALL have port byte_en  input  DATA_W/8  per-byte write mask; bit i gates data_in[8i+7:8i].
REQ-010 SHALL have port data_in  input  DATA_W  write data.
REQ-011 SHALL have port rd_enb  input  1  read enable.
REQ-012 SHALL have port rd_addr  input  ADDR_W  read address.
REQ-013 SHALL have port data_out  output  DATA_W  registered read data.
REQ-014 SHALL have port rd_valid  output  1  data_out updated by a read accepted the previous cycle.
REQ-015 SHALL have port busy  output  1  clear sweep in progress; accesses ignored.

Function
REQ-016 SHALL implement FSM states CLEAR and READY; CLEAR entered from reset or from READY on clr_req=1.
REQ-017 In CLEAR, SHALL write zero to address clr_ptr each cycle, clr_ptr counting 0..DEPTH-1; after writing DEPTH-1, next state READY, clr_ptr back to 0.
REQ-018 Clear SHALL take exactly DEPTH cycles; busy=1 for every CLEAR cycle, 0 in READY.
REQ-019 In CLEAR, wr_enb, rd_enb and clr_req SHALL be ignored; rd_valid=0; data_out holds.
REQ-020 In READY, wr_enb=1 SHALL update only bytes with byte_en=1 at wr_addr on the same edge; byte_en=0 leaves memory unchanged.
REQ-021 In READY, rd_enb=1 SHALL load mem[rd_addr] into data_out at that edge (latency 1); rd_valid=1 the following cycle.
REQ-022 rd_enb=0 SHALL hold data_out and drive rd_valid=0 next cycle.
REQ-023 Read and write to same address same cycle: RD_MODE=0 returns old word; RD_MODE=1 returns old word merged with data_in on byte_en lanes.
REQ-024 Read and write to different addresses same cycle SHALL both complete independently.
REQ-025 clr_req and access in same READY cycle: the access SHALL complete; CLEAR starts next cycle.
REQ-026 Addresses SHALL wrap naturally at ADDR_W bits; no out-of-range case exists.

Reset
REQ-027 When rst=0 at a rising edge: data_out=0, rd_valid=0, clr_ptr=0, state=CLEAR, busy=1 from the next cycle.
REQ-028 Reset asserted mid-clear SHALL restart the sweep at address 0.
REQ-029 Memory array contents SHALL not be reset directly; only the sweep zeroes them.
REQ-030 While rst=0 held, busy SHALL remain 1 and no memory write SHALL occur.

Structure
REQ-031 Shared package ram_pkg SHALL hold the FSM state enum (CLEAR, READY) and RD_MODE encodings RD_OLD=0, RD_WT=1.
REQ-032 SHALL instantiate one sub-module ram_clr_fsm (state, clr_ptr, busy); array, byte merge and read register stay in ram_dp_clr.
REQ-033 Array SHALL be one DEPTH x DATA_W register array inferable as block or distributed RAM.

Verification (DATA_W=16, ADDR_W=3 unless stated)
REQ-034 Release rst after 2 cycles -> busy=1 exactly 8 cycles then 0; reads of addresses 0..7 return 0x0000 with rd_valid=1.
REQ-035 Write 0xABCD addr 4 byte_en=11, then 0x1234 addr 4 byte_en=01 -> read addr 4 returns 0xAB34 one cycle after rd_enb.
REQ-036 RD_MODE=0 and RD_MODE=1 builds, addr 5 holds 0x0005, same-cycle write 0x000A byte_en=11 and read addr 5 -> 0x0005 vs 0x000A; later read 0x000A both.
REQ-037 Fill addr 0..7 with 0x1111, pulse clr_req -> 8 busy cycles, wr_enb during busy to addr 2 with 0xFFFF ignored; all reads return 0x0000.
REQ-038 Assert rst during clear at clr_ptr=5, release -> busy lasts full 8 cycles from release; rd_valid=0 throughout.
REQ-039 Write 0x00FF addr 1 while reading addr 6 same cycle -> next cycle data_out=0x0000 (addr 6), later read addr 1 = 0x00FF.
